// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with memory-ready handshakes,
// timeout and illegal-opcode traps, external stall, and a retired-instruction counter.
module multicycle_control #(
  parameter int OPW    = 6,
  parameter int ALUOPW = 4,
  parameter int TMO    = 15,
  parameter int CNTW   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OPW-1:0]    op,
  input  logic              imem_ready,
  input  logic              dmem_ready,
  input  logic              zero,
  input  logic              stall,
  output logic [2:0]        state,
  output logic              imem_read,
  output logic              ir_wen,
  output logic              pc_wen,
  output logic [1:0]        pc_src,
  output logic              wen,
  output logic              alusrc,
  output logic              reg_dst,
  output logic              mem_to_reg,
  output logic              link,
  output logic [ALUOPW-1:0] aluop,
  output logic              mem_read,
  output logic              mem_write,
  output logic              done,
  output logic              illegal,
  output logic              timeout,
  output logic [CNTW-1:0]   retired
);

  localparam logic [OPW-1:0] OP_ADD  = OPW'(6'h00);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(6'h01);
  localparam logic [OPW-1:0] OP_AND  = OPW'(6'h02);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(6'h03);
  localparam logic [OPW-1:0] OP_COM  = OPW'(6'h04);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(6'h05);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(6'h10);
  localparam logic [OPW-1:0] OP_LW   = OPW'(6'h20);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'h21);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'h30);
  localparam logic [OPW-1:0] OP_J    = OPW'(6'h38);
  localparam logic [OPW-1:0] OP_JAL  = OPW'(6'h39);
  localparam logic [OPW-1:0] OP_JR   = OPW'(6'h3a);

  localparam int CW = $clog2(TMO + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  state_t          st_q, st_nxt;
  logic [OPW-1:0]  op_q;
  logic [CW-1:0]   cnt_q;
  logic            tmo_hit, ill_hit, waiting;

  function automatic logic is_legal(input logic [OPW-1:0] o);
    case (o)
      OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_COM, OP_MUL, OP_ADDI,
      OP_LW, OP_BEQ, OP_SW, OP_J, OP_JAL, OP_JR: is_legal = 1'b1;
      default:                                   is_legal = 1'b0;
    endcase
  endfunction

  assign state = st_q;

  always_comb begin
    st_nxt     = st_q;
    tmo_hit    = 1'b0;
    ill_hit    = 1'b0;
    imem_read  = 1'b0;
    ir_wen     = 1'b0;
    pc_wen     = 1'b0;
    pc_src     = 2'd0;
    wen        = 1'b0;
    alusrc     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    link       = 1'b0;
    aluop      = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    done       = 1'b0;

    case (st_q)
      S_FETCH: begin
        imem_read = 1'b1;
        if (imem_ready) begin
          ir_wen = 1'b1;
          pc_wen = 1'b1;
          st_nxt = S_DECODE;
        end else if (cnt_q == CW'(TMO - 1)) begin
          tmo_hit = 1'b1;
          st_nxt  = S_TRAP;
        end
      end
      // DECODE looks at the live opcode; op_q only becomes valid after this cycle.
      S_DECODE: begin
        if (!is_legal(op)) begin
          ill_hit = 1'b1;
          st_nxt  = S_TRAP;
        end else if (op == OP_J || op == OP_JAL || op == OP_JR) begin
          pc_wen = 1'b1;
          pc_src = (op == OP_JR) ? 2'd3 : 2'd2;
          wen    = (op == OP_JAL);
          link   = (op == OP_JAL);
          done   = 1'b1;
          st_nxt = S_FETCH;
        end else begin
          st_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        aluop  = op_q[ALUOPW-1:0];
        alusrc = (op_q == OP_ADDI) || (op_q == OP_LW) || (op_q == OP_SW);
        if (op_q == OP_BEQ) begin
          pc_src = 2'd1;
          pc_wen = zero;
          done   = 1'b1;
          st_nxt = S_FETCH;
        end else if (op_q == OP_LW || op_q == OP_SW) begin
          st_nxt = S_MEM;
        end else begin
          st_nxt = S_WB;
        end
      end
      S_MEM: begin
        alusrc    = 1'b1;
        aluop     = op_q[ALUOPW-1:0];
        mem_read  = (op_q == OP_LW);
        mem_write = (op_q == OP_SW);
        if (dmem_ready) begin
          if (op_q == OP_LW) begin
            st_nxt = S_WB;
          end else begin
            done   = 1'b1;
            st_nxt = S_FETCH;
          end
        end else if (cnt_q == CW'(TMO - 1)) begin
          tmo_hit = 1'b1;
          st_nxt  = S_TRAP;
        end
      end
      S_WB: begin
        wen        = 1'b1;
        done       = 1'b1;
        reg_dst    = !((op_q == OP_ADDI) || (op_q == OP_LW));
        mem_to_reg = (op_q == OP_LW);
        st_nxt     = S_FETCH;
      end
      default: st_nxt = S_TRAP;
    endcase

    // Stall suppresses every write enable but keeps request strobes and selects steady.
    if (stall) begin
      ir_wen = 1'b0;
      pc_wen = 1'b0;
      wen    = 1'b0;
      done   = 1'b0;
    end

    // Outputs go quiet the instant reset asserts, even though the state reads FETCH.
    if (!rst_n) begin
      imem_read  = 1'b0;
      ir_wen     = 1'b0;
      pc_wen     = 1'b0;
      pc_src     = 2'd0;
      wen        = 1'b0;
      alusrc     = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      link       = 1'b0;
      aluop      = '0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      done       = 1'b0;
    end
  end

  assign waiting = ((st_q == S_FETCH) && !imem_ready) || ((st_q == S_MEM) && !dmem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= S_FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
      retired <= '0;
      illegal <= 1'b0;
      timeout <= 1'b0;
    end else if (!stall) begin
      st_q <= st_nxt;
      if (st_q == S_DECODE) op_q <= op;
      if (st_nxt != st_q)   cnt_q <= '0;
      else if (waiting)     cnt_q <= cnt_q + 1'b1;
      if (done)    retired <= retired + 1'b1;
      if (ill_hit) illegal <= 1'b1;
      if (tmo_hit) timeout <= 1'b1;
    end
  end

endmodule
